morra_match_driver: RTL and testbench
=====================================

Name: morra_match_driver

Overview:
- Initiator side of the MorraCinese game interface. It accepts start and move commands over a valid/ready port and drives `primo`/`secondo`/`inizia` into the game FSM.
- It samples the game's `manche`/`partita` response and returns one result per command. It keeps a per-match scoreboard.
- It sits between a host/sequencer and the MorraCinese core, replacing hand-driven stimulus.

Parameters:
- GAME_LAT, 1: cycles from the posedge at which the game captures inputs to the posedge at which its `manche`/`partita` are sampled (1..4).
- CNT_W, 5: width of scoreboard counters; counters saturate at 2^CNT_W-1.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  driver can accept a command
- cmd_start  in  1  1 = start new partita (payload = max-manche code), 0 = play move
- cmd_primo  in  2  move of player 1 (01 sasso, 10 carta, 11 forbice, 00 none) or code[3:2]
- cmd_secondo  in  2  move of player 2, or code[1:0]
- primo  out  2  to game
- secondo  out  2  to game
- inizia  out  1  to game
- manche  in  2  from game: 00 invalid/none, 01 primo wins, 10 secondo wins, 11 tie
- partita  in  2  from game: 00 running, 01 primo, 10 secondo, 11 tie
- res_valid  out  1  one-cycle result pulse
- res_manche  out  2  captured manche
- res_partita  out  2  captured partita
- res_err  out  1  move command rejected (no active partita)
- match_active  out  1  partita in progress
- wins_primo, wins_secondo, ties, invalid_cnt  out  CNT_W each  scoreboard

Behaviour:
- Clock and reset: a single clock domain is used. Reset is synchronous and active-low. Port names are clk and rst_n.
- Reset values:
  - State = IDLE; cmd_ready=1.
  - primo=00, secondo=00, inizia=0.
  - res_*=0, match_active=0, all counters 0.
- Reset mid-operation: an in-flight command is abandoned and no res_valid is issued.
- FSM states: IDLE, DRIVE, WAIT, REPORT.
- IDLE:
  - cmd_ready=1; game outputs held at 00/00, inizia=0 (a bubble the game ignores).
  - On cmd_valid&cmd_ready the command is registered.
  - If the command is a move and match_active=0: go to REPORT with res_err=1; the game is not driven and counters are unchanged.
  - Otherwise go to DRIVE.
- DRIVE (exactly 1 cycle):
  - primo/secondo = registered payload; inizia = registered cmd_start.
  - If cmd_start: clear all counters and set match_active=1 at this edge.
  - Next state: WAIT.
- WAIT (GAME_LAT cycles):
  - Game inputs return to bubble (00/00, inizia=0).
  - On the final WAIT edge, capture manche/partita into res_manche/res_partita; go to REPORT.
- REPORT (1 cycle):
  - res_valid=1, cmd_ready=0; go to IDLE.
  - res_manche/res_partita/res_err are held until the next REPORT.
- Scoreboard update, on the REPORT edge, for non-start, non-err commands only:
  - Captured manche 01 → wins_primo+1; 10 → wins_secondo+1; 11 → ties+1; 00 → invalid_cnt+1.
  - All counters saturate at max.
- Match end:
  - Captured partita≠00 on a move command clears match_active on the REPORT edge.
  - A start command while match_active=1 is legal: it restarts and clears counters.
- Throughput: one command per 3+GAME_LAT cycles; cmd_ready=0 outside IDLE.
- Start response: its captured manche/partita are reported but never counted.

Test Plan:
- Reset then start 00/10 (max 6) → inizia=1 for exactly one cycle with primo=00, secondo=10; res_valid after 2+GAME_LAT cycles; match_active=1; counters 0.
- Partita 2 sequence against the MorraCinese core: start 00/01, then moves 01/11, 10/01, 01/10, 10/11, 11/01 → res_manche 01,01,10,10,10; final res_partita=10; wins_primo=2, wins_secondo=3; match_active=0.
- Move 01/10 with no active partita → res_err=1, primo/secondo stay 00, inizia stays 0, counters unchanged.
- Partita 1 move 11/10 right after a 01/10 loss → captured manche 00 (invalid), invalid_cnt=1, win counters unchanged.
- cmd_valid held high continuously → cmd_ready pulses once per 3+GAME_LAT cycles and no command is lost or duplicated; rst_n=0 during WAIT → next cycle is IDLE, no res_valid, all outputs at reset values.
- Force the manche=01 response 32 times with CNT_W=5 → wins_primo saturates at 31; a start command then clears it to 0.

Source files
------------

// File: rtl/morra_match_driver.sv
// morra_match_driver: initiator that drives MorraCinese game inputs per command and scores the returned results
module morra_match_driver #(
  parameter int GAME_LAT = 1,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_start,
  input  logic [1:0]       cmd_primo,
  input  logic [1:0]       cmd_secondo,
  output logic [1:0]       primo,
  output logic [1:0]       secondo,
  output logic             inizia,
  input  logic [1:0]       manche,
  input  logic [1:0]       partita,
  output logic             res_valid,
  output logic [1:0]       res_manche,
  output logic [1:0]       res_partita,
  output logic             res_err,
  output logic             match_active,
  output logic [CNT_W-1:0] wins_primo,
  output logic [CNT_W-1:0] wins_secondo,
  output logic [CNT_W-1:0] ties,
  output logic [CNT_W-1:0] invalid_cnt
);
  typedef enum logic [1:0] {IDLE, DRIVE, WAIT, REPORT} state_t;
  localparam logic [CNT_W-1:0] MAX = '1;
  state_t state, state_n;
  logic start_r;
  logic [1:0] p_r, s_r;
  logic [2:0] wcnt;
  logic accept, err_cmd, last_wait, count_en;
  assign err_cmd   = !cmd_start && !match_active;
  assign accept    = state == IDLE && cmd_valid;
  assign last_wait = state == WAIT && wcnt == 3'(GAME_LAT - 1);
  // only real moves that reached the game feed the scoreboard
  assign count_en  = state == REPORT && !start_r && !res_err;
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end
  always_comb begin
    state_n   = state;
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    primo     = 2'b00;
    secondo   = 2'b00;
    inizia    = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_n = err_cmd ? REPORT : DRIVE;
      end
      DRIVE: begin
        primo   = p_r;
        secondo = s_r;
        inizia  = start_r;
        state_n = WAIT;
      end
      WAIT:    state_n = last_wait ? REPORT : WAIT;
      default: begin
        res_valid = 1'b1;
        state_n   = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_r      <= 1'b0;
      p_r          <= 2'b00;
      s_r          <= 2'b00;
      wcnt         <= 3'd0;
      res_manche   <= 2'b00;
      res_partita  <= 2'b00;
      res_err      <= 1'b0;
      match_active <= 1'b0;
      wins_primo   <= '0;
      wins_secondo <= '0;
      ties         <= '0;
      invalid_cnt  <= '0;
    end else begin
      wcnt <= state == WAIT ? wcnt + 3'd1 : 3'd0;
      if (accept) begin
        start_r <= cmd_start;
        p_r     <= cmd_primo;
        s_r     <= cmd_secondo;
      end
      if (accept && err_cmd) res_err <= 1'b1;
      if (last_wait) begin
        res_err     <= 1'b0;
        res_manche  <= manche;
        res_partita <= partita;
      end
      if (state == DRIVE && start_r) begin
        match_active <= 1'b1;
        wins_primo   <= '0;
        wins_secondo <= '0;
        ties         <= '0;
        invalid_cnt  <= '0;
      end
      if (count_en) begin
        if (res_manche == 2'b01 && wins_primo != MAX)   wins_primo   <= wins_primo + 1'b1;
        if (res_manche == 2'b10 && wins_secondo != MAX) wins_secondo <= wins_secondo + 1'b1;
        if (res_manche == 2'b11 && ties != MAX)         ties         <= ties + 1'b1;
        if (res_manche == 2'b00 && invalid_cnt != MAX)  invalid_cnt  <= invalid_cnt + 1'b1;
        if (res_partita != 2'b00) match_active <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_morra_match_driver.sv
// tb_morra_match_driver: directed checks of the match driver against a one-cycle-latency game stand-in
module tb_morra_match_driver;
  logic clk = 0, rst_n = 0;
  logic cmd_valid = 0, cmd_ready, cmd_start = 0;
  logic [1:0] cmd_primo = 0, cmd_secondo = 0, primo, secondo, manche, partita;
  logic inizia, res_valid, res_err, match_active;
  logic [1:0] res_manche, res_partita;
  logic [4:0] wins_primo, wins_secondo, ties, invalid_cnt;
  logic [1:0] resp_m = 0, resp_p = 0, ini_p = 0, ini_s = 0;
  int checks = 0, errors = 0, ini_cnt = 0, drv_cnt = 0;
  int acc, rv, c0, c1, d0, i0;

  morra_match_driver #(.GAME_LAT(1), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_primo(cmd_primo), .cmd_secondo(cmd_secondo),
    .primo(primo), .secondo(secondo), .inizia(inizia), .manche(manche), .partita(partita),
    .res_valid(res_valid), .res_manche(res_manche), .res_partita(res_partita), .res_err(res_err),
    .match_active(match_active), .wins_primo(wins_primo), .wins_secondo(wins_secondo),
    .ties(ties), .invalid_cnt(invalid_cnt)
  );

  always #5 clk = ~clk;

  // game stand-in: presents the response only in the cycle after it was driven, garbage otherwise
  always @(posedge clk) begin
    manche  <= (inizia || primo != 0 || secondo != 0) ? resp_m : ~resp_m;
    partita <= (inizia || primo != 0 || secondo != 0) ? resp_p : ~resp_p;
  end

  always @(negedge clk) begin
    if (inizia) begin
      ini_cnt++;
      ini_p = primo;
      ini_s = secondo;
    end
    if (inizia || primo != 0 || secondo != 0) drv_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input string tag, input logic st, input logic [1:0] p, input logic [1:0] s,
                      input logic [1:0] m, input logic [1:0] pa, input int exp_lat);
    int n;
    resp_m = m;
    resp_p = pa;
    cmd_start = st;
    cmd_primo = p;
    cmd_secondo = s;
    cmd_valid = 1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, 32'(n < 20), 1);
    @(negedge clk);
    cmd_valid = 0;
    n = 1;
    while (!res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, exp_lat);
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_outs", {primo, secondo, inizia, res_valid, res_err, match_active}, 0);
    chk("rst_cnts", {wins_primo, wins_secondo, ties, invalid_cnt}, 0);
    rst_n = 1;
    @(negedge clk);
    d0 = drv_cnt;
    send("err", 0, 2'b01, 2'b10, 2'b01, 2'b00, 1);
    chk("err_flag", res_err, 1);
    chk("err_nodrive", drv_cnt, d0);
    chk("err_state", {match_active, wins_primo, wins_secondo, ties, invalid_cnt}, 0);
    i0 = ini_cnt;
    send("start6", 1, 2'b00, 2'b10, 2'b00, 2'b00, 3);
    chk("start6_ini", ini_cnt - i0, 1);
    chk("start6_code", {ini_p, ini_s}, 4'b0010);
    chk("start6_res", {res_err, match_active, res_manche, res_partita}, 6'b010000);
    chk("start6_cnts", {wins_primo, wins_secondo, ties, invalid_cnt}, 0);
    send("p2_start", 1, 2'b00, 2'b01, 2'b00, 2'b00, 3);
    send("p2_m1", 0, 2'b01, 2'b11, 2'b01, 2'b00, 3);
    chk("p2_m1_res", res_manche, 2'b01);
    send("p2_m2", 0, 2'b10, 2'b01, 2'b01, 2'b00, 3);
    chk("p2_m2_res", res_manche, 2'b01);
    send("p2_m3", 0, 2'b01, 2'b10, 2'b10, 2'b00, 3);
    chk("p2_m3_res", res_manche, 2'b10);
    send("p2_m4", 0, 2'b10, 2'b11, 2'b10, 2'b00, 3);
    chk("p2_m4_res", {res_manche, match_active}, 3'b101);
    send("p2_m5", 0, 2'b11, 2'b01, 2'b10, 2'b10, 3);
    chk("p2_m5_res", {res_manche, res_partita}, 4'b1010);
    chk("p2_cnts", {wins_primo, wins_secondo, ties, invalid_cnt}, {5'd2, 5'd3, 5'd0, 5'd0});
    chk("p2_end", match_active, 0);
    send("p1_start", 1, 2'b00, 2'b00, 2'b00, 2'b00, 3);
    chk("p1_cleared", {wins_primo, wins_secondo, ties, invalid_cnt}, 0);
    send("p1_m1", 0, 2'b01, 2'b10, 2'b10, 2'b00, 3);
    send("p1_m2", 0, 2'b11, 2'b10, 2'b00, 2'b00, 3);
    chk("p1_inv", {wins_primo, wins_secondo, ties, invalid_cnt}, {5'd0, 5'd1, 5'd0, 5'd1});
    resp_m = 2'b11;
    resp_p = 2'b00;
    cmd_start = 0;
    cmd_primo = 2'b01;
    cmd_secondo = 2'b11;
    cmd_valid = 1;
    acc = 0;
    rv = 0;
    c0 = -1;
    c1 = -1;
    for (int c = 0; c < 12; c++) begin
      if (cmd_ready) begin
        acc++;
        if (acc == 1) c0 = c;
        if (acc == 2) c1 = c;
      end
      if (res_valid) rv++;
      @(negedge clk);
      if (acc == 3) cmd_valid = 0;
    end
    cmd_valid = 0;
    chk("bp_accepts", acc, 3);
    chk("bp_results", rv, 3);
    chk("bp_period", c1 - c0, 4);
    chk("bp_ties", {ties, invalid_cnt, wins_secondo}, {5'd3, 5'd1, 5'd1});
    send("sat_start", 1, 2'b00, 2'b11, 2'b00, 2'b00, 3);
    for (int k = 0; k < 32; k++) send("sat_mv", 0, 2'b01, 2'b11, 2'b01, 2'b00, 3);
    chk("sat_max", {wins_primo, wins_secondo, match_active}, {5'd31, 5'd0, 1'b1});
    send("sat_clear", 1, 2'b00, 2'b11, 2'b01, 2'b00, 3);
    chk("sat_cleared", {wins_primo, res_manche}, {5'd0, 2'b01});
    cmd_start = 1;
    cmd_primo = 2'b00;
    cmd_secondo = 2'b10;
    cmd_valid = 1;
    @(negedge clk);
    cmd_valid = 0;
    chk("rw_drive", inizia, 1);
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    chk("rw_ready", cmd_ready, 1);
    chk("rw_outs", {primo, secondo, inizia, res_valid, res_err, match_active, res_manche, res_partita}, 0);
    chk("rw_cnts", {wins_primo, wins_secondo, ties, invalid_cnt}, 0);
    rst_n = 1;
    rv = 0;
    repeat (6) begin
      @(negedge clk);
      if (res_valid) rv++;
    end
    chk("rw_nores", rv, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
